// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer and the benches that drive an ALU
// against it: opcodes, FSM state encoding and flag bit positions.
package alu_sequencer_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_LDI   = 4'b0010;
  localparam logic [3:0] OP_SHOWR = 4'b1111;

  // Flag vector layout is {CF,ZF,SF,OF}
  localparam int FLAG_CF = 3;
  localparam int FLAG_ZF = 2;
  localparam int FLAG_SF = 1;
  localparam int FLAG_OF = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } seq_state_t;

  // Opcodes that need the ALU and therefore walk READ/EXEC/WB
  function automatic logic uses_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SHOWR);
  endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// Small register file for the sequencer: two combinational read ports and one
// synchronous write port, cleared by synchronous reset.
module seq_regfile #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4,
  parameter int AW     = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [AW-1:0]     rd_addr1,
  input  logic [AW-1:0]     rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data1 = regs[rd_addr1];
  assign rd_data2 = regs[rd_addr2];

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer that feeds an external registered ALU: single-cycle
// NOP/LDI retire from IDLE, ADD/SHOWR go through READ, EXEC and WB.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        instr,
  input  logic [DATA_W-1:0] imm,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [3:0]        alu_flags,
  output logic [DATA_W-1:0] show_data,
  output logic              show_valid,
  output logic [3:0]        flags,
  output logic              done,
  output logic              illegal
);

  seq_state_t state, next_state;

  logic [3:0] op_q;
  logic [1:0] rd_q;
  logic [1:0] rs2_q;

  logic [3:0] opcode;
  logic       transfer;

  logic              wr_en;
  logic [1:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;

  assign opcode   = instr[7:4];
  assign transfer = instr_valid && instr_ready;

  // LDI writes on its accept edge so a following ADD already sees the value;
  // ADD writes at the end of WB. The two can never coincide.
  assign wr_en   = (transfer && (opcode == OP_LDI)) ||
                   ((state == S_WB) && (op_q == OP_ADD));
  assign wr_addr = (state == S_WB) ? rd_q : instr[3:2];
  assign wr_data = (state == S_WB) ? alu_res : imm;

  seq_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .AW     (2)
  ) u_regfile (
    .clock    (clock),
    .reset    (reset),
    .rd_addr1 (rd_q),
    .rd_addr2 (rs2_q),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (transfer && uses_alu(opcode)) next_state = S_READ;
      end
      S_READ:  next_state = S_EXEC;
      S_EXEC:  next_state = S_WB;
      S_WB:    next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath registers; pulses default low and are raised for a single cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q       <= OP_NOP;
      rd_q       <= '0;
      rs2_q      <= '0;
      alu_op     <= OP_NOP;
      alu_in1    <= '0;
      alu_in2    <= '0;
      show_data  <= '0;
      show_valid <= 1'b0;
      flags      <= '0;
      done       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      alu_op     <= OP_NOP;
      show_valid <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      if (transfer) begin
        op_q  <= opcode;
        rd_q  <= instr[3:2];
        rs2_q <= instr[1:0];
        if (!uses_alu(opcode)) begin
          done    <= 1'b1;
          illegal <= (opcode != OP_NOP) && (opcode != OP_LDI);
        end
      end
      case (state)
        S_READ: begin
          alu_in1 <= rd_data1;
          alu_in2 <= rd_data2;
          alu_op  <= op_q;
        end
        S_EXEC: done <= 1'b1;
        S_WB: begin
          if (op_q == OP_ADD) flags <= alu_flags;
          if (op_q == OP_SHOWR) begin
            show_data  <= alu_res;
            show_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a registered ALU model attached;
// register contents are observed through SHOWR.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [7:0] instr = '0;
  logic [7:0] imm = '0;
  logic [3:0] alu_op;
  logic [7:0] alu_in1, alu_in2;
  logic [7:0] alu_res;
  logic [3:0] alu_flags;
  logic [7:0] show_data;
  logic       show_valid;
  logic [3:0] flags;
  logic       done, illegal;
  logic [8:0] sum;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  alu_sequencer #(.DATA_W(8), .NREG(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .imm         (imm),
    .alu_op      (alu_op),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_res     (alu_res),
    .alu_flags   (alu_flags),
    .show_data   (show_data),
    .show_valid  (show_valid),
    .flags       (flags),
    .done        (done),
    .illegal     (illegal)
  );

  // Registered ALU: result and flags appear the cycle after alu_op is presented
  assign sum = {1'b0, alu_in1} + {1'b0, alu_in2};

  always_ff @(posedge clock) begin
    if (reset) begin
      alu_res   <= '0;
      alu_flags <= '0;
    end else begin
      case (alu_op)
        OP_ADD: begin
          alu_res            <= sum[7:0];
          alu_flags[FLAG_CF] <= sum[8];
          alu_flags[FLAG_ZF] <= (sum[7:0] == 8'h00);
          alu_flags[FLAG_SF] <= sum[7];
          alu_flags[FLAG_OF] <= (alu_in1[7] == alu_in2[7]) && (sum[7] != alu_in1[7]);
        end
        OP_SHOWR: alu_res <= alu_in1;
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic applyStimulus(input logic [7:0] i, input logic [7:0] d);
    int waited = 0;
    instr_valid = 1'b1;
    instr       = i;
    imm         = d;
    while (!instr_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("accept ready", 32'(instr_ready), 1);
    @(posedge clock);
    @(negedge clock);
    instr_valid = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int waited = 0;
    while (!done && waited < 10) begin
      @(negedge clock);
      waited++;
    end
    checkOutput(tag, 32'(done), 1);
    @(negedge clock);
  endtask

  task automatic showCheck(input string tag, input logic [1:0] r, input logic [7:0] exp);
    int waited = 0;
    applyStimulus({OP_SHOWR, r, 2'b00}, 8'h00);
    while (!show_valid && waited < 10) begin
      @(negedge clock);
      waited++;
    end
    checkOutput({tag, " valid"}, 32'(show_valid), 1);
    checkOutput(tag, 32'(show_data), 32'(exp));
    @(negedge clock);
    checkOutput({tag, " pulse"}, 32'(show_valid), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkOutput("rst ready", 32'(instr_ready), 1);
    checkOutput("rst done", 32'(done), 0);
    checkOutput("rst illegal", 32'(illegal), 0);
    checkOutput("rst show_valid", 32'(show_valid), 0);
    checkOutput("rst alu_op", 32'(alu_op), 0);
    checkOutput("rst alu_in1", 32'(alu_in1), 0);
    checkOutput("rst alu_in2", 32'(alu_in2), 0);
    checkOutput("rst show_data", 32'(show_data), 0);
    checkOutput("rst flags", 32'(flags), 0);

    // LDI r1,0x05 ; LDI r2,0x03 back to back
    applyStimulus(8'h24, 8'h05);
    checkOutput("ldi1 done", 32'(done), 1);
    checkOutput("ldi1 illegal", 32'(illegal), 0);
    applyStimulus(8'h28, 8'h03);
    checkOutput("ldi2 done", 32'(done), 1);
    @(negedge clock);
    checkOutput("ldi2 done drop", 32'(done), 0);

    // ADD r1,r2 cycle by cycle
    applyStimulus(8'h16, 8'h00);
    checkOutput("add read alu_op", 32'(alu_op), 0);
    checkOutput("add read done", 32'(done), 0);
    checkOutput("add read ready", 32'(instr_ready), 0);
    @(negedge clock);
    checkOutput("add exec alu_op", 32'(alu_op), 1);
    checkOutput("add exec in1", 32'(alu_in1), 'h05);
    checkOutput("add exec in2", 32'(alu_in2), 'h03);
    @(negedge clock);
    checkOutput("add wb done", 32'(done), 1);
    checkOutput("add wb alu_op", 32'(alu_op), 0);
    checkOutput("add wb in1", 32'(alu_in1), 'h05);
    checkOutput("add wb ready", 32'(instr_ready), 0);
    @(negedge clock);
    checkOutput("add idle ready", 32'(instr_ready), 1);
    checkOutput("add idle done", 32'(done), 0);
    checkOutput("add flags", 32'(flags), 'b0000);
    showCheck("r1 sum", 2'd1, 8'h08);
    showCheck("r2 kept", 2'd2, 8'h03);

    // 0x7F + 0x01 signed overflow
    applyStimulus(8'h20, 8'h7F);
    applyStimulus(8'h2C, 8'h01);
    applyStimulus(8'h13, 8'h00);
    waitDone("add7f done");
    checkOutput("add7f flags", 32'(flags), 'b0011);
    showCheck("r0 sum", 2'd0, 8'h80);
    checkOutput("showr keeps flags", 32'(flags), 'b0011);

    // 0xFF + 0xFF with rd==rs2, LDI held valid while busy
    applyStimulus(8'h28, 8'hFF);
    applyStimulus(8'h1A, 8'h00);
    instr_valid = 1'b1;
    instr = 8'h2C;
    imm = 8'h42;
    @(negedge clock);
    checkOutput("dbl exec in1", 32'(alu_in1), 'hFF);
    checkOutput("dbl exec in2", 32'(alu_in2), 'hFF);
    checkOutput("busy ready exec", 32'(instr_ready), 0);
    @(negedge clock);
    checkOutput("dbl wb done", 32'(done), 1);
    checkOutput("busy ready wb", 32'(instr_ready), 0);
    @(negedge clock);
    checkOutput("held ready idle", 32'(instr_ready), 1);
    checkOutput("dbl flags", 32'(flags), 'b1010);
    @(negedge clock);
    checkOutput("held ldi done", 32'(done), 1);
    instr_valid = 1'b0;
    showCheck("r2 dbl", 2'd2, 8'hFE);
    showCheck("r3 held", 2'd3, 8'h42);

    // 0x80 + 0x80 wraps to zero
    applyStimulus(8'h24, 8'h80);
    applyStimulus(8'h15, 8'h00);
    waitDone("add80 done");
    checkOutput("add80 flags", 32'(flags), 'b1101);
    showCheck("r1 wrap", 2'd1, 8'h00);

    // Undefined opcode 0101
    applyStimulus(8'h58, 8'h55);
    checkOutput("illegal done", 32'(done), 1);
    checkOutput("illegal pulse", 32'(illegal), 1);
    @(negedge clock);
    checkOutput("illegal drop", 32'(illegal), 0);
    checkOutput("illegal done drop", 32'(done), 0);
    showCheck("r2 after illegal", 2'd2, 8'hFE);
    checkOutput("illegal flags", 32'(flags), 'b1101);

    // Reset during EXEC of ADD r1,r2 with an LDI held on the bus
    applyStimulus(8'h24, 8'h05);
    applyStimulus(8'h28, 8'h03);
    applyStimulus(8'h16, 8'h00);
    instr_valid = 1'b1;
    instr = 8'h2C;
    imm = 8'hAA;
    @(negedge clock);
    checkOutput("abort exec alu_op", 32'(alu_op), 1);
    checkOutput("abort exec ready", 32'(instr_ready), 0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("abort done", 32'(done), 0);
    checkOutput("abort ready", 32'(instr_ready), 1);
    checkOutput("abort alu_op", 32'(alu_op), 0);
    checkOutput("abort alu_in1", 32'(alu_in1), 0);
    checkOutput("abort flags", 32'(flags), 0);
    @(negedge clock);
    checkOutput("rst priority done", 32'(done), 0);
    reset = 1'b0;
    instr_valid = 1'b0;
    @(negedge clock);
    checkOutput("abort late done", 32'(done), 0);
    checkOutput("abort show_valid", 32'(show_valid), 0);
    showCheck("r1 aborted", 2'd1, 8'h00);
    showCheck("r3 not loaded", 2'd3, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, operand/result width; SHALL match the ALU datapath width.
REQ-002 Parameter NREG, default 4, register-file depth; register address width SHALL be 2.
REQ-003 clock  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instr_valid  input  1  instruction offered.
REQ-006 instr_ready  output  1  sequencer can accept; a transfer SHALL occur when valid and ready are both high on a rising edge.
REQ-007 instr  input  8  [7:4] opcode, [3:2] rd/rs1, [1:0] rs2.
REQ-008 imm  input  8  immediate, sampled with instr.
REQ-009 alu_op  output  4  ALU opcode: 0000 NOP, 0001 ADD, 1111 SHOWR.
REQ-010 alu_in1, alu_in2  output  8 each  ALU operands.
REQ-011 alu_res  input  8  ALU result.
REQ-012 alu_flags  input  4  {CF,ZF,SF,OF} as registered by the ALU.
REQ-013 show_data  output  8  last SHOWR value; show_valid  output  1  one-cycle pulse when show_data updates.
REQ-014 flags  output  4  {CF,ZF,SF,OF} of the last completed ADD.
REQ-015 done  output  1  one-cycle pulse per retired instruction; illegal  output  1  one-cycle pulse with done for an undefined opcode.

Function
REQ-016 Opcodes: 0000 NOP, 0001 ADD rd<=rd+rs2, 0010 LDI rd<=imm, 1111 SHOWR show rd; all others illegal, retired as NOP.
REQ-017 FSM states: IDLE, READ, EXEC, WB; instr_ready SHALL be high only in IDLE.
REQ-018 IDLE->READ on transfer of ADD or SHOWR; transfer of NOP, LDI or illegal SHALL stay in IDLE, retire next cycle (done high, LDI write done) -- throughput 1 per cycle.
REQ-019 READ: register operands rd->alu_in1, rs2->alu_in2 into output registers; ->EXEC.
REQ-020 EXEC: alu_op SHALL equal the captured opcode for exactly this cycle, otherwise 0000; alu_in1/alu_in2 stable through EXEC and WB; ->WB.
REQ-021 WB: ADD SHALL write alu_res to rd and alu_flags to flags; SHOWR SHALL load show_data with alu_res and pulse show_valid; done pulses at the end of WB; ->IDLE.
REQ-022 ADD/SHOWR latency: accept edge T, done high in cycle T+3, instr_ready high in T+4.
REQ-023 Arithmetic is done only by the ALU; sequencer SHALL not compute sums; 8-bit wrap-around is the ALU's responsibility, written back unmodified.
REQ-024 rd==rs2 SHALL read the same register into both operands (e.g. doubling).
REQ-025 instr_valid while busy SHALL be ignored (not accepted, not lost-tracked); requester holds it.
REQ-026 Register writes occur only in WB (ADD) or the retire cycle (LDI); at most one write per cycle.

Reset
REQ-027 reset SHALL force IDLE, register file to 0, alu_op 0000, alu_in1/alu_in2 0, show_data 0, flags 0, show_valid/done/illegal 0, instr_ready 1 from the next cycle.
REQ-028 reset mid-instruction SHALL abort it: no write-back, no done, no show_valid.
REQ-029 reset SHALL take priority over a coincident instr transfer.

Structure
REQ-030 Opcode constants, FSM state encoding and flag bit positions SHALL live in a shared package used by this block and the ALU bench.
REQ-031 Register file SHALL be sub-module seq_regfile (2 combinational read ports, 1 synchronous write port, synchronous reset).

Verification
REQ-032 reset, LDI r1,0x05 then LDI r2,0x03 back-to-back -> two done pulses in consecutive cycles, r1=0x05, r2=0x03.
REQ-033 ADD r1,r2 (r1=0x05,r2=0x03) -> alu_op=0001 for one cycle, done at T+3, r1=0x08, flags=0000.
REQ-034 LDI r0,0x7F; LDI r3,0x01; ADD r0,r3 -> r0=0x80, flags SF=1, OF=1, CF=0, ZF=0.
REQ-035 LDI r2,0xFF; ADD r2,r2 -> r2=0xFE, CF=1, SF=1; then LDI r1,0x00-style wrap 0x80+0x80 -> 0x00, CF=1, ZF=1, OF=1.
REQ-036 SHOWR r1 (r1=0x08) -> show_data=0x08 with one show_valid pulse; flags unchanged; opcode 0101 -> done and illegal pulse, no register change.
REQ-037 reset asserted in EXEC of ADD r1,r2 -> no done, r1=0x00, instr_ready=1 next cycle, instr_valid held during busy not accepted until IDLE.
